sram_like_arbiter: RTL and testbench

//  Merges the core's two sram-like master ports (inst, data) onto one shared sram-like slave port
//  (toward the AXI bridge). Per-request arbitration; grant locked until the request is accepted.

---
 rtl/sram_like_arbiter_pkg.sv | 22 ++
 rtl/sram_like_arbiter_src_id_fifo.sv | 57 +++++
 rtl/sram_like_arbiter.sv | 139 +++++++++++++
 tb/tb_sram_like_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_arbiter_pkg.sv
// Shared types and constants for the sram-like two-master arbiter.
//   state_e       : arbiter FSM encoding (idle, locked to inst, locked to data)
//   SrcInst/Data  : one-bit source IDs stored in the response-routing FIFO
//   pick_data     : arbitration decision used while idle
package sram_like_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StLockInst = 2'd1,
    StLockData = 2'd2
  } state_e;

  localparam logic SrcInst = 1'b0;
  localparam logic SrcData = 1'b1;

  // Data wins unless round-robin is on, both ports compete and data won last time.
  function automatic logic pick_data(input logic data_req, input logic inst_req,
                                     input logic rr_en, input logic rr_last);
    return data_req & (~rr_en | ~inst_req | (rr_last == SrcInst));
  endfunction

endpackage

// File: rtl/sram_like_arbiter_src_id_fifo.sv
// In-order FIFO of 1-bit source IDs, one entry per request accepted by the slave.
//   i_clk, i_resetn : clock, asynchronous active-low reset
//   i_push, i_id    : enqueue source ID (ignored when full)
//   i_pop           : dequeue head (ignored when empty)
//   o_head          : source ID of the oldest outstanding request
//   o_empty         : no outstanding requests
//   o_count         : number of outstanding requests
module sram_like_arbiter_src_id_fifo #(
  parameter int unsigned Depth = 4
) (
  input  logic                       i_clk,
  input  logic                       i_resetn,
  input  logic                       i_push,
  input  logic                       i_id,
  input  logic                       i_pop,
  output logic                       o_head,
  output logic                       o_empty,
  output logic [$clog2(Depth+1)-1:0] o_count
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [Depth-1:0] r_mem;
  logic [PtrW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic             w_full, w_push, w_pop;

  assign w_full  = (r_count == CntW'(Depth));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~w_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_id;
        // Explicit wrap so non-power-of-2 depths work.
        r_wr_ptr <= (r_wr_ptr == LastPtr) ? '0 : r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == LastPtr) ? '0 : r_rd_ptr + PtrW'(1);
      end
      if (w_push && !w_pop)      r_count <= r_count + CntW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CntW'(1);
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Merges the inst and data sram-like master ports onto one sram-like slave port.
// Per-request arbitration, grant locked until accepted; responses are routed back through an
// in-order source-ID FIFO.
//   clk, resetn                  : clock, asynchronous active-low reset
//   inst_* / data_*              : master request fields in, addr_ok/data_ok/rdata out
//   slave_*                      : muxed request out, addr_ok/data_ok/rdata in
//   proto_err                    : sticky, data_ok seen with nothing outstanding
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int unsigned OUTSTANDING = 4,
  parameter bit          RR_EN       = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        slave_req,
  output logic        slave_wr,
  output logic [1:0]  slave_size,
  output logic [3:0]  slave_wstrb,
  output logic [31:0] slave_addr,
  output logic [31:0] slave_wdata,
  input  logic        slave_addr_ok,
  input  logic        slave_data_ok,
  input  logic [31:0] slave_rdata,
  output logic        proto_err
);

  localparam int unsigned CntW = $clog2(OUTSTANDING + 1);

  state_e          r_state;
  logic            r_rr_last;
  logic            r_proto_err;
  logic            w_gnt_vld, w_gnt_src;
  logic            w_full, w_empty, w_head;
  logic            w_accept, w_pop;
  logic [CntW-1:0] w_count;

  assign w_full = (w_count == CntW'(OUTSTANDING));

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_src = SrcInst;
    case (r_state)
      StIdle: begin
        if (!w_full) begin
          if (pick_data(data_req, inst_req, RR_EN, r_rr_last)) begin
            w_gnt_vld = 1'b1;
            w_gnt_src = SrcData;
          end else if (inst_req) begin
            w_gnt_vld = 1'b1;
            w_gnt_src = SrcInst;
          end
        end
      end
      StLockInst: begin
        w_gnt_vld = 1'b1;
        w_gnt_src = SrcInst;
      end
      StLockData: begin
        w_gnt_vld = 1'b1;
        w_gnt_src = SrcData;
      end
      default: ;
    endcase
  end

  // Outputs are forced low while reset is asserted so the bridge sees nothing mid-reset.
  assign slave_req   = w_gnt_vld & ~w_full & resetn;
  assign slave_wr    = (w_gnt_src == SrcData) ? data_wr    : inst_wr;
  assign slave_size  = (w_gnt_src == SrcData) ? data_size  : inst_size;
  assign slave_wstrb = (w_gnt_src == SrcData) ? data_wstrb : inst_wstrb;
  assign slave_addr  = (w_gnt_src == SrcData) ? data_addr  : inst_addr;
  assign slave_wdata = (w_gnt_src == SrcData) ? data_wdata : inst_wdata;

  assign w_accept     = slave_req & slave_addr_ok;
  assign inst_addr_ok = w_accept & (w_gnt_src == SrcInst);
  assign data_addr_ok = w_accept & (w_gnt_src == SrcData);

  assign w_pop        = slave_data_ok & ~w_empty & resetn;
  assign inst_data_ok = w_pop & (w_head == SrcInst);
  assign data_data_ok = w_pop & (w_head == SrcData);
  assign inst_rdata   = slave_rdata;
  assign data_rdata   = slave_rdata;
  assign proto_err    = r_proto_err;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= StIdle;
      r_rr_last   <= SrcInst;
      r_proto_err <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_gnt_vld && !slave_addr_ok) begin
            r_state <= (w_gnt_src == SrcData) ? StLockData : StLockInst;
          end
        end
        StLockInst, StLockData: begin
          if (w_accept) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
      if (w_accept) r_rr_last <= w_gnt_src;
      if (slave_data_ok && w_empty) r_proto_err <= 1'b1;
    end
  end

  sram_like_arbiter_src_id_fifo #(
    .Depth (OUTSTANDING)
  ) u_fifo (
    .i_clk    (clk),
    .i_resetn (resetn),
    .i_push   (w_accept),
    .i_id     (w_gnt_src),
    .i_pop    (w_pop),
    .o_head   (w_head),
    .o_empty  (w_empty),
    .o_count  (w_count)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
module tb_sram_like_arbiter;

  localparam logic [31:0] IAddr = 32'h1000_0040;
  localparam logic [31:0] DAddr = 32'h2000_0080;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        slave_addr_ok, slave_data_ok;
  logic [31:0] slave_rdata;

  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        slave_req, slave_wr, proto_err;
  logic [1:0]  slave_size;
  logic [3:0]  slave_wstrb;
  logic [31:0] slave_addr, slave_wdata;

  logic        rr_inst_addr_ok, rr_inst_data_ok, rr_data_addr_ok, rr_data_data_ok;
  logic [31:0] rr_inst_rdata, rr_data_rdata;
  logic        rr_slave_req, rr_slave_wr, rr_proto_err;
  logic [1:0]  rr_slave_size;
  logic [3:0]  rr_slave_wstrb;
  logic [31:0] rr_slave_addr, rr_slave_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sram_like_arbiter #(.OUTSTANDING(4), .RR_EN(1'b0)) u_dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .slave_req(slave_req), .slave_wr(slave_wr), .slave_size(slave_size),
    .slave_wstrb(slave_wstrb), .slave_addr(slave_addr), .slave_wdata(slave_wdata),
    .slave_addr_ok(slave_addr_ok), .slave_data_ok(slave_data_ok), .slave_rdata(slave_rdata),
    .proto_err(proto_err)
  );

  sram_like_arbiter #(.OUTSTANDING(4), .RR_EN(1'b1)) u_dut_rr (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(rr_inst_addr_ok),
    .inst_data_ok(rr_inst_data_ok), .inst_rdata(rr_inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(rr_data_addr_ok),
    .data_data_ok(rr_data_data_ok), .data_rdata(rr_data_rdata),
    .slave_req(rr_slave_req), .slave_wr(rr_slave_wr), .slave_size(rr_slave_size),
    .slave_wstrb(rr_slave_wstrb), .slave_addr(rr_slave_addr), .slave_wdata(rr_slave_wdata),
    .slave_addr_ok(slave_addr_ok), .slave_data_ok(slave_data_ok), .slave_rdata(slave_rdata),
    .proto_err(rr_proto_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'h0;
    inst_addr = IAddr; inst_wdata = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'h0;
    data_addr = DAddr; data_wdata = 32'h0;
    slave_addr_ok = 1'b0; slave_data_ok = 1'b0; slave_rdata = 32'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    #1;
  endtask

  initial begin
    int n_d, n_i;
    clear_inputs();
    resetn = 1'b0;
    #2;
    check_eq("rst_slave_req", {31'b0, slave_req}, 32'd0);
    check_eq("rst_count", 32'(u_dut.w_count), 32'd0);
    check_eq("rst_proto_err", {31'b0, proto_err}, 32'd0);
    do_reset();

    // Fixed priority: data wins, inst served on the next cycle.
    inst_req = 1'b1; data_req = 1'b1; slave_addr_ok = 1'b1;
    data_wstrb = 4'hF; inst_wstrb = 4'h3;
    #1;
    check_eq("fp_data_addr_ok", {31'b0, data_addr_ok}, 32'd1);
    check_eq("fp_inst_addr_ok", {31'b0, inst_addr_ok}, 32'd0);
    check_eq("fp_slave_addr", slave_addr, DAddr);
    check_eq("fp_slave_wstrb", {28'b0, slave_wstrb}, 32'hF);
    tick();
    data_req = 1'b0;
    #1;
    check_eq("fp_inst_next", {31'b0, inst_addr_ok}, 32'd1);
    check_eq("fp_inst_addr", slave_addr, IAddr);
    check_eq("fp_inst_wstrb", {28'b0, slave_wstrb}, 32'h3);
    tick();
    inst_req = 1'b0; slave_addr_ok = 1'b0;
    #1;
    check_eq("fp_count2", 32'(u_dut.w_count), 32'd2);
    slave_data_ok = 1'b1; slave_rdata = 32'hAA;
    #1;
    check_eq("fp_resp0_data", {31'b0, data_data_ok}, 32'd1);
    check_eq("fp_resp0_inst", {31'b0, inst_data_ok}, 32'd0);
    check_eq("fp_resp0_rdata", data_rdata, 32'hAA);
    tick();
    slave_rdata = 32'hBB;
    #1;
    check_eq("fp_resp1_inst", {31'b0, inst_data_ok}, 32'd1);
    check_eq("fp_resp1_rdata", inst_rdata, 32'hBB);
    tick();
    slave_data_ok = 1'b0;
    #1;
    check_eq("fp_drained", 32'(u_dut.w_count), 32'd0);

    // Lock: data granted while addr_ok low; inst rising must not steal the port.
    do_reset();
    data_req = 1'b1;
    #1;
    check_eq("lk_req_c0", {31'b0, slave_req}, 32'd1);
    check_eq("lk_addr_c0", slave_addr, DAddr);
    tick();
    inst_req = 1'b1;
    #1;
    check_eq("lk_addr_c1", slave_addr, DAddr);
    check_eq("lk_inst_ok_c1", {31'b0, inst_addr_ok}, 32'd0);
    tick();
    #1;
    check_eq("lk_addr_c2", slave_addr, DAddr);
    tick();
    slave_addr_ok = 1'b1;
    #1;
    check_eq("lk_data_ok_c3", {31'b0, data_addr_ok}, 32'd1);
    check_eq("lk_inst_ok_c3", {31'b0, inst_addr_ok}, 32'd0);
    tick();
    data_req = 1'b0;
    #1;
    check_eq("lk_inst_ok_c4", {31'b0, inst_addr_ok}, 32'd1);
    check_eq("lk_addr_c4", slave_addr, IAddr);
    tick();

    // In-order routing: issue I,D,I,D, respond later.
    do_reset();
    slave_addr_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      inst_req = (k % 2 == 0);
      data_req = (k % 2 == 1);
      #1;
      check_eq("ord_issue_i", {31'b0, inst_addr_ok}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check_eq("ord_issue_d", {31'b0, data_addr_ok}, (k % 2 == 1) ? 32'd1 : 32'd0);
      tick();
    end
    inst_req = 1'b0; data_req = 1'b0; slave_addr_ok = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      slave_data_ok = 1'b1;
      slave_rdata = 32'h11 * (k + 1);
      #1;
      check_eq("ord_resp_i", {31'b0, inst_data_ok}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check_eq("ord_resp_d", {31'b0, data_data_ok}, (k % 2 == 1) ? 32'd1 : 32'd0);
      check_eq("ord_rdata", (k % 2 == 0) ? inst_rdata : data_rdata, 32'h11 * (k + 1));
      tick();
    end
    slave_data_ok = 1'b0;

    // Full: four outstanding block further requests until one response arrives.
    do_reset();
    data_req = 1'b1; slave_addr_ok = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    #1;
    check_eq("full_count", 32'(u_dut.w_count), 32'd4);
    check_eq("full_slave_req", {31'b0, slave_req}, 32'd0);
    check_eq("full_addr_ok", {31'b0, data_addr_ok}, 32'd0);
    slave_data_ok = 1'b1; slave_rdata = 32'h55;
    #1;
    check_eq("full_pop_dok", {31'b0, data_data_ok}, 32'd1);
    check_eq("full_pop_blocked", {31'b0, data_addr_ok}, 32'd0);
    tick();
    slave_data_ok = 1'b0;
    #1;
    check_eq("full_after_pop_cnt", 32'(u_dut.w_count), 32'd3);
    check_eq("full_after_pop_ok", {31'b0, data_addr_ok}, 32'd1);
    tick();
    data_req = 1'b0;
    #1;
    check_eq("full_refill", 32'(u_dut.w_count), 32'd4);

    // Round-robin instance: grants alternate D,I,D,I with both ports requesting.
    do_reset();
    inst_req = 1'b1; data_req = 1'b1; slave_addr_ok = 1'b1;
    n_d = 0; n_i = 0;
    for (int k = 0; k < 100; k++) begin
      slave_data_ok = (k != 0);
      #1;
      check_eq("rr_grant_d", {31'b0, rr_data_addr_ok}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check_eq("rr_grant_i", {31'b0, rr_inst_addr_ok}, (k % 2 == 1) ? 32'd1 : 32'd0);
      if (rr_data_addr_ok) n_d++;
      if (rr_inst_addr_ok) n_i++;
      tick();
    end
    check_eq("rr_count_d", n_d, 32'd50);
    check_eq("rr_count_i", n_i, 32'd50);
    check_eq("rr_no_proto_err", {31'b0, rr_proto_err}, 32'd0);

    // Stray response with an empty FIFO.
    do_reset();
    slave_data_ok = 1'b1; slave_rdata = 32'h99;
    #1;
    check_eq("pe_inst_dok", {31'b0, inst_data_ok}, 32'd0);
    check_eq("pe_data_dok", {31'b0, data_data_ok}, 32'd0);
    tick();
    slave_data_ok = 1'b0;
    #1;
    check_eq("pe_set", {31'b0, proto_err}, 32'd1);
    tick();
    check_eq("pe_sticky", {31'b0, proto_err}, 32'd1);

    // Async reset mid-burst with requests and responses still asserted.
    inst_req = 1'b1; slave_addr_ok = 1'b1;
    tick();
    data_req = 1'b1; slave_data_ok = 1'b1;
    #1;
    resetn = 1'b0;
    #1;
    check_eq("ar_slave_req", {31'b0, slave_req}, 32'd0);
    check_eq("ar_addr_ok", {30'b0, inst_addr_ok, data_addr_ok}, 32'd0);
    check_eq("ar_data_ok", {30'b0, inst_data_ok, data_data_ok}, 32'd0);
    check_eq("ar_proto_err", {31'b0, proto_err}, 32'd0);
    check_eq("ar_count", 32'(u_dut.w_count), 32'd0);
    clear_inputs();
    tick();
    resetn = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
